uart_rx_deserializer: RTL and testbench

- Serial receive front-end of the transceiver, directly upstream of the parity-check decoder stage.
- Oversamples the asynchronous serial line rx and deserializes each frame into a DATA_WIDTH+1 word: data bits in [DATA_WIDTH-1:0], received parity bit in [DATA_WIDTH].
- Frame: 1 start (0), DATA_WIDTH data bits LSB first, 1 parity bit, 1 stop (1).
- Parity is not checked here; the word is passed on so the decoder can check it.

---
 rtl/uart_rx_deserializer_pkg.sv | 19 +
 rtl/uart_rx_deserializer_sync_2ff.sv | 25 ++
 rtl/uart_rx_deserializer.sv | 116 +++++++++++
 tb/tb_uart_rx_deserializer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_deserializer_pkg.sv
// Shared constants for the UART receive front-end.
// State encoding, frame bit levels and default bit period.
package uart_rx_deserializer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int CLKS_PER_BIT_DEF = 16;

endpackage

// File: rtl/uart_rx_deserializer_sync_2ff.sv
// Two-flop synchronizer for an asynchronous level input.
// Resets to 1 so an idle-high line reads idle out of reset.
module sync_2ff (
  input  logic clk,
  input  logic arst,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q;
  logic ff2_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ff1_q <= 1'b1;
      ff2_q <= 1'b1;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receiver: start, data LSB first, parity, stop.
// Emits {parity, data} unchecked for the downstream parity decoder.
module uart_rx_deserializer
  import uart_rx_deserializer_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  rx,
  output logic [DATA_WIDTH:0]   data_out,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LBIT = BW'(DATA_WIDTH - 1);

  logic                rx_s;
  rx_state_e           state_q;
  logic [CW-1:0]       cnt_q;
  logic [BW-1:0]       bit_q;
  logic [DATA_WIDTH:0] sr_q;
  logic [DATA_WIDTH:0] data_q;
  logic                valid_q;
  logic                ferr_q;

  sync_2ff u_sync (
    .clk  (clk),
    .arst (arst),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_s == START_BIT) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == HALF) begin
            cnt_q <= '0;
            bit_q <= '0;
            // a start bit gone high by mid-bit was a glitch
            state_q <= (rx_s == START_BIT) ? DATA : IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            sr_q  <= {rx_s, sr_q[DATA_WIDTH:1]};
            bit_q <= bit_q + BW'(1);
            if (bit_q == LBIT) state_q <= PARITY;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        PARITY: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            sr_q    <= {rx_s, sr_q[DATA_WIDTH:1]};
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            if (rx_s == STOP_BIT) begin
              data_q  <= sr_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_s == STOP_BIT) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer.
// Frame table plus glitch, reset-abort and back-to-back sequences.
module tb_uart_rx_deserializer;

  localparam int CPB = 16;

  logic       clk;
  logic       arst;
  logic       rx;
  logic [8:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx_deserializer #(
    .DATA_WIDTH   (8),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    int         exp_v;
    int         exp_f;
    int         exp_do;
    int         exp_perr;
  } vec_t;

  int nchk;
  int nerr;
  int cyc;
  int start_cyc;
  int vcnt;
  int fcnt;
  int bcnt;
  int both;
  int vcyc[8];
  int vdat[8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      if (vcnt < 8) begin
        vcyc[vcnt] = cyc;
        vdat[vcnt] = int'(data_out);
      end
      vcnt++;
    end
    if (frame_err) fcnt++;
    if (valid && frame_err) both++;
    if (busy) bcnt++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input int n);
    rx = b;
    step(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic s);
    start_cyc = cyc;
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(d[i], CPB);
    drive(p, CPB);
    drive(s, CPB);
  endtask

  task automatic clr();
    vcnt = 0;
    fcnt = 0;
    bcnt = 0;
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 1, 0, 'h0A5, 0};
    tbl[1] = '{8'h01, 1'b1, 1'b1, 1, 0, 'h101, 0};
    tbl[2] = '{8'h01, 1'b0, 1'b1, 1, 0, 'h001, 1};
    tbl[3] = '{8'h3C, 1'b0, 1'b0, 0, 1, 'h001, 1};
    tbl[4] = '{8'h55, 1'b0, 1'b1, 1, 0, 'h055, 0};

    nchk = 0; nerr = 0; cyc = 0; both = 0;
    clr();
    arst = 1'b1;
    rx   = 1'b1;
    step(3);
    @(negedge clk);
    chk("rst_data", int'(data_out), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk); #1;
    arst = 1'b0;
    step(5);

    for (int k = 0; k < 5; k++) begin
      clr();
      send_frame(tbl[k].d, tbl[k].p, tbl[k].s);
      if (!tbl[k].s) begin
        drive(1'b0, 100);
        chk($sformatf("v%0d_wait_busy", k), int'(busy), 1);
        rx = 1'b1;
      end
      step(8);
      chk($sformatf("v%0d_valid_cnt", k), vcnt, tbl[k].exp_v);
      chk($sformatf("v%0d_ferr_cnt", k), fcnt, tbl[k].exp_f);
      chk($sformatf("v%0d_data", k), int'(data_out), tbl[k].exp_do);
      chk($sformatf("v%0d_perr", k), int'(^data_out), tbl[k].exp_perr);
      chk($sformatf("v%0d_busy", k), int'(busy), 0);
      if (tbl[k].exp_v == 1)
        chk($sformatf("v%0d_latency", k), vcyc[0] - start_cyc, 171);
    end

    clr();
    drive(1'b0, 5);
    drive(1'b1, 30);
    chk("glitch_busy_cycles", bcnt, 8);
    chk("glitch_valid", vcnt, 0);
    chk("glitch_ferr", fcnt, 0);
    chk("glitch_data", int'(data_out), 'h055);

    clr();
    drive(1'b0, CPB);
    drive(1'b1, CPB);
    drive(1'b0, CPB);
    drive(1'b0, CPB / 2);
    arst = 1'b1;
    step(1);
    @(negedge clk);
    chk("arst_data", int'(data_out), 0);
    chk("arst_valid", int'(valid), 0);
    chk("arst_ferr", int'(frame_err), 0);
    chk("arst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rx = 1'b1;
    step(3);
    arst = 1'b0;
    step(2 * CPB);
    chk("abort_valid", vcnt, 0);
    chk("abort_ferr", fcnt, 0);
    chk("abort_busy", int'(busy), 0);
    send_frame(8'h81, 1'b0, 1'b1);
    step(8);
    chk("post_rst_valid", vcnt, 1);
    chk("post_rst_data", int'(data_out), 'h081);

    clr();
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h00, 1'b0, 1'b1);
    step(8);
    chk("b2b_valid_cnt", vcnt, 2);
    chk("b2b_ferr_cnt", fcnt, 0);
    chk("b2b_data0", vdat[0], 'h0FF);
    chk("b2b_data1", vdat[1], 'h000);
    chk("b2b_gap", vcyc[1] - vcyc[0], 11 * CPB);
    chk("never_both", both, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
